t02_wb_arbiter: RTL

Write-back arbiter and load scoreboard for the register file. It shares the register file's single write port between the ALU result path and the memory-load path using round-robin arbitration, and drives the port from a registered output stage. It also tracks destination registers of outstanding loads and flags read-after-write hazards to the decode/stall logic.

---
 rtl/t02_wb_pkg.sv | 23 ++
 rtl/t02_wb_scoreboard.sv | 43 ++++
 rtl/t02_wb_arbiter.sv | 93 +++++++++
 3 files changed

// File: rtl/t02_wb_pkg.sv
// t02_wb_pkg: shared types and default widths for the write-back arbiter.
//   wb_src_t   : which requester produced a write (ALU or MEM).
//   wb_stage_t : registered output-stage contents {valid, src, index, data}.
// The stage struct is sized by WB_DATA_W/WB_ADDR_W. The top must be built with
// those widths.
package t02_wb_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 5;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } wb_src_t;

    typedef struct packed {
        logic                 valid;
        wb_src_t              src;
        logic [WB_ADDR_W-1:0] index;
        logic [WB_DATA_W-1:0] data;
    } wb_stage_t;

endpackage

// File: rtl/t02_wb_scoreboard.sv
// t02_wb_scoreboard: one busy bit per register for outstanding loads.
//   busy_set/busy_index   : mark a load destination outstanding (index 0 ignored).
//   clear/clear_index     : a mem-sourced write is in the output stage this cycle.
//   rs1/rs2 -> hazard     : either source register is outstanding.
// A set and a clear that hit the same index in the same cycle leave the bit set.
module t02_wb_scoreboard
    import t02_wb_pkg::*;
#(
    parameter int ADDR_W = WB_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              busy_set,
    input  logic [ADDR_W-1:0] busy_index,
    input  logic              clear,
    input  logic [ADDR_W-1:0] clear_index,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    output logic              hazard
);

    localparam int N = 2 ** ADDR_W;

    logic [N-1:0] busy;
    logic [N-1:0] set_mask;
    logic [N-1:0] clr_mask;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        set_mask[busy_index] = busy_set;
        clr_mask[clear_index] = clear;
        set_mask[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) busy <= '0;
        else     busy <= (busy & ~clr_mask) | set_mask;
    end

    assign hazard = busy[rs1] | busy[rs2];

endmodule

// File: rtl/t02_wb_arbiter.sv
// t02_wb_arbiter: round-robin write-back arbiter with a registered write port
// and an optional load scoreboard.
//   alu_valid/alu_index/alu_data -> alu_ready : ALU result requester.
//   mem_valid/mem_index/mem_data -> mem_ready : load data requester.
//   reg_write/write_index/write_data          : register file write port (one cycle after accept).
//   busy_set/busy_index, rs1/rs2 -> hazard    : load scoreboard.
// Define T02_WB_SCOREBOARD_EN to build the scoreboard. Otherwise hazard is 0 and
// the scoreboard inputs are ignored.
module t02_wb_arbiter
    import t02_wb_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_index,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_index,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    output logic              reg_write,
    output logic [ADDR_W-1:0] write_index,
    output logic [DATA_W-1:0] write_data,
    input  logic              busy_set,
    input  logic [ADDR_W-1:0] busy_index,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    output logic              hazard
);

    wb_stage_t         stage;
    wb_src_t           last_grant;
    logic              grant_alu;
    logic              grant_mem;
    logic [ADDR_W-1:0] sel_index;
    logic [DATA_W-1:0] sel_data;

    // A tie goes to whichever requester was not granted last.
    always_comb begin
        grant_alu = !rst && alu_valid && (!mem_valid || last_grant == SRC_MEM);
        grant_mem = !rst && mem_valid && (!alu_valid || last_grant == SRC_ALU);
        sel_index = grant_mem ? mem_index : alu_index;
        sel_data  = grant_mem ? mem_data : alu_data;
    end

    assign alu_ready = grant_alu;
    assign mem_ready = grant_mem;

    // Index-0 transfers are accepted but never marked as a pending write.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage      <= '0;
            last_grant <= SRC_MEM;
        end else begin
            stage.valid <= 1'b0;
            if (grant_alu || grant_mem) begin
                stage.valid <= sel_index != '0;
                stage.src   <= grant_mem ? SRC_MEM : SRC_ALU;
                stage.index <= sel_index;
                stage.data  <= sel_data;
                last_grant  <= grant_mem ? SRC_MEM : SRC_ALU;
            end
        end
    end

    // Gating with rst drops a pending write when reset lands on it.
    assign reg_write   = stage.valid && !rst;
    assign write_index = stage.index;
    assign write_data  = stage.data;

`ifdef T02_WB_SCOREBOARD_EN
    t02_wb_scoreboard #(.ADDR_W(ADDR_W)) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .busy_set   (busy_set),
        .busy_index (busy_index),
        .clear      (stage.valid && stage.src == SRC_MEM),
        .clear_index(stage.index),
        .rs1        (rs1),
        .rs2        (rs2),
        .hazard     (hazard)
    );
`else
    logic unused_sb;
    assign unused_sb = ^{busy_set, busy_index, rs1, rs2, stage.src};
    assign hazard    = 1'b0;
`endif

endmodule
